// File: rtl/demux1to2_buf.sv
// -----------------------------------------------------------------------------
// demux1to2_buf
//
// Buffered 1-to-2 demultiplexer. One input stream (valid/ready) is steered by
// `sel` into one of two independent FIFOs. Each FIFO drains through its own
// valid/ready output port, so the two consumers may stall independently.
//
// Parameters
//   WIDTH : data width of the input and both outputs (default 4)
//   DEPTH : entries per output FIFO, 2 or 4 only (default 2)
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset (clears storage, pointers, counts)
//   d         : input data word
//   sel       : destination select, 0 -> y0, 1 -> y1
//   in_valid  : d/sel valid this cycle
//   in_ready  : FIFO addressed by sel is not full
//   y0/y1     : head of FIFO 0 / FIFO 1
//   y0_valid/y1_valid : FIFO 0 / FIFO 1 non-empty
//   y0_ready/y1_ready : consumer takes the head this cycle
//   cnt0/cnt1 : 8-bit wrapping count of words accepted into each FIFO
//               (present only when DEMUX1TO2_STATS_EN is defined)
//
// Optional feature macro: DEMUX1TO2_STATS_EN
// -----------------------------------------------------------------------------
module demux1to2_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready
`ifdef DEMUX1TO2_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]    OCC_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]    OCC_ONE   = CW'(1);
    localparam logic [CW-1:0]    OCC_ZERO  = {CW{1'b0}};
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]    PTR_ZERO  = {PW{1'b0}};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    // Per-FIFO state, index 0 feeds y0 and index 1 feeds y1.
    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [PW-1:0]    rptr_q [2];
    logic [PW-1:0]    rptr_d [2];
    logic [PW-1:0]    wptr_q [2];
    logic [PW-1:0]    wptr_d [2];
    logic [CW-1:0]    occ_q  [2];
    logic [CW-1:0]    occ_d  [2];

    logic [1:0] valid_s;
    logic [1:0] ready_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;

    // Handshake decode: in_ready looks only at registered occupancy, so a full
    // FIFO refuses input even while it is being drained in the same cycle.
    always_comb begin
        valid_s[0] = (occ_q[0] != OCC_ZERO);
        valid_s[1] = (occ_q[1] != OCC_ZERO);
        ready_s    = {y1_ready, y0_ready};
        if (sel) begin
            in_ready = (occ_q[1] != OCC_FULL);
        end else begin
            in_ready = (occ_q[0] != OCC_FULL);
        end
        push_s[0] = in_valid & in_ready & ~sel;
        push_s[1] = in_valid & in_ready & sel;
        pop_s     = valid_s & ready_s;
    end

    // Next-state for pointers and occupancy; push+pop together leaves the
    // occupancy unchanged while both pointers advance.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                wptr_d[i] = wptr_q[i] + PTR_ONE;
            end else begin
                wptr_d[i] = wptr_q[i];
            end
            if (pop_s[i]) begin
                rptr_d[i] = rptr_q[i] + PTR_ONE;
            end else begin
                rptr_d[i] = rptr_q[i];
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   occ_d[i] = occ_q[i] + OCC_ONE;
                2'b01:   occ_d[i] = occ_q[i] - OCC_ONE;
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    // State registers and storage; reset clears storage so heads read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rptr_q[i] <= PTR_ZERO;
                wptr_q[i] <= PTR_ZERO;
                occ_q[i]  <= OCC_ZERO;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= DATA_ZERO;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rptr_q[i] <= rptr_d[i];
                wptr_q[i] <= wptr_d[i];
                occ_q[i]  <= occ_d[i];
                if (push_s[i]) begin
                    mem_q[i][wptr_q[i]] <= d;
                end
            end
        end
    end

    assign y0       = mem_q[0][rptr_q[0]];
    assign y1       = mem_q[1][rptr_q[1]];
    assign y0_valid = valid_s[0];
    assign y1_valid = valid_s[1];

`ifdef DEMUX1TO2_STATS_EN
    logic [7:0] stat_q [2];

    // Accepted-word counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q[0] <= 8'd0;
            stat_q[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    stat_q[i] <= stat_q[i] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = stat_q[0];
    assign cnt1 = stat_q[1];
`endif

endmodule

// File: tb/tb_demux1to2_buf.sv
// -----------------------------------------------------------------------------
// Testbench for demux1to2_buf. Inputs are driven after the falling edge and
// outputs sampled before the next rising edge. A queue-per-output model holds
// the words each consumer should still receive.
// -----------------------------------------------------------------------------
module tb_demux1to2_buf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y1;
    logic             y1_valid;
    logic             y1_ready;
`ifdef DEMUX1TO2_STATS_EN
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
`endif

    demux1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready)
`ifdef DEMUX1TO2_STATS_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Words each consumer is still owed, oldest first.
    logic [WIDTH-1:0] m0[$];
    logic [WIDTH-1:0] m1[$];

    task automatic drive(input logic iv, input logic s, input logic [WIDTH-1:0] dd,
                         input logic r0, input logic r1);
        in_valid = iv;
        sel      = s;
        d        = dd;
        y0_ready = r0;
        y1_ready = r1;
    endtask

    // One clock cycle: advance the model by the rules of the handshake.
    task automatic tick();
        logic acc, p0, p1, s;
        logic [WIDTH-1:0] dd;
        s   = sel;
        dd  = d;
        acc = in_valid && (s ? (m1.size() != DEPTH) : (m0.size() != DEPTH));
        p0  = y0_ready && (m0.size() > 0);
        p1  = y1_ready && (m1.size() > 0);
        @(posedge clk);
        if (rst) begin
            m0.delete();
            m1.delete();
        end else begin
            if (p0) void'(m0.pop_front());
            if (p1) void'(m1.pop_front());
            if (acc) begin
                if (s) m1.push_back(dd);
                else   m0.push_back(dd);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checks++; if (y0_valid !== 1'b0) begin failures++; $display("FAIL reset_y0_valid got=%0b want=0", y0_valid); end
        checks++; if (y1_valid !== 1'b0) begin failures++; $display("FAIL reset_y1_valid got=%0b want=0", y1_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (y0 !== 4'd0) begin failures++; $display("FAIL reset_y0 got=%0d want=0", y0); end
        checks++; if (y1 !== 4'd0) begin failures++; $display("FAIL reset_y1 got=%0d want=0", y1); end
`ifdef DEMUX1TO2_STATS_EN
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
`endif
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
        tick();
        checks++; if (y0 !== 4'd5 || y0_valid !== 1'b1) begin failures++; $display("FAIL basic_y0 got=%0d/%0b want=5/1", y0, y0_valid); end
        drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
        tick();
        checks++; if (y1 !== 4'd9 || y1_valid !== 1'b1) begin failures++; $display("FAIL basic_y1 got=%0d/%0b want=9/1", y1, y1_valid); end
        checks++; if (y0 !== 4'd5 || y0_valid !== 1'b1) begin failures++; $display("FAIL basic_y0_hold got=%0d/%0b want=5/1", y0, y0_valid); end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b/%0b want=0/0", y0_valid, y1_valid); end
    endtask

    task automatic test_full();
        drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_sel0 got=%0b want=0", in_ready); end
        sel = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_sel1 got=%0b want=1", in_ready); end
        checks++; if (y0 !== 4'd1) begin failures++; $display("FAIL full_head got=%0d want=1", y0); end
        // Full FIFO being drained still refuses the word 3.
        drive(1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_draining got=%0b want=0", in_ready); end
        tick();
        checks++; if (y0 !== 4'd2 || y0_valid !== 1'b1) begin failures++; $display("FAIL full_second got=%0d/%0b want=2/1", y0, y0_valid); end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        checks++; if (y0_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0b want=0", y0_valid); end
        // Ready while empty is ignored.
        drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
        tick();
        checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL empty_ready got=%0b/%0b/%0b want=0/0/1", y0_valid, y1_valid, in_ready);
        end
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] val;
        drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            val = 4'(7 + k);
            drive(1'b1, 1'b0, val, 1'b1, 1'b0);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pp_ready k=%0d got=%0b want=1", k, in_ready); end
            tick();
            checks++; if (y0 !== val || y0_valid !== 1'b1) begin failures++; $display("FAIL pp_data k=%0d got=%0d/%0b want=%0d/1", k, y0, y0_valid, val); end
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        checks++; if (y0_valid !== 1'b0) begin failures++; $display("FAIL pp_final_empty got=%0b want=0", y0_valid); end
    endtask

    task automatic test_reset_full();
        drive(1'b1, 1'b0, 4'd10, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 4'd11, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 4'd12, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 4'd13, 1'b0, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd15, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin failures++; $display("FAIL rstfull_valid got=%0b/%0b want=0/0", y0_valid, y1_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstfull_ready got=%0b want=1", in_ready); end
        checks++; if (y0 !== 4'd0 || y1 !== 4'd0) begin failures++; $display("FAIL rstfull_data got=%0d/%0d want=0/0", y0, y1); end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin failures++; $display("FAIL rstfull_stale got=%0b/%0b want=0/0", y0_valid, y1_valid); end
    endtask

    task automatic test_random();
        logic hold, iv, s, r0, r1, exp_ready;
        logic [WIDTH-1:0] dd;
        hold = 1'b0;
        iv = 1'b0; s = 1'b0; dd = 4'd0;
        for (int i = 0; i < 500; i++) begin
            if (!hold) begin
                iv = ($urandom_range(0, 3) != 0);
                s  = 1'($urandom_range(0, 1));
                dd = 4'($urandom_range(0, 15));
            end
            r0 = ($urandom_range(0, 2) == 0);
            r1 = ($urandom_range(0, 2) != 0);
            drive(iv, s, dd, r0, r1);
            #1;
            exp_ready = s ? (m1.size() != DEPTH) : (m0.size() != DEPTH);
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b want=%0b", i, in_ready, exp_ready); end
            checks++; if (y0_valid !== (m0.size() != 0)) begin failures++; $display("FAIL rnd_y0_valid i=%0d got=%0b want=%0b", i, y0_valid, m0.size() != 0); end
            checks++; if (y1_valid !== (m1.size() != 0)) begin failures++; $display("FAIL rnd_y1_valid i=%0d got=%0b want=%0b", i, y1_valid, m1.size() != 0); end
            if (m0.size() != 0) begin
                checks++; if (y0 !== m0[0]) begin failures++; $display("FAIL rnd_y0 i=%0d got=%0d want=%0d", i, y0, m0[0]); end
            end
            if (m1.size() != 0) begin
                checks++; if (y1 !== m1[0]) begin failures++; $display("FAIL rnd_y1 i=%0d got=%0d want=%0d", i, y1, m1[0]); end
            end
            hold = iv && !exp_ready;
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) tick();
        checks++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0b/%0b want=0/0", y0_valid, y1_valid); end
    endtask

`ifdef DEMUX1TO2_STATS_EN
    task automatic test_stats();
        logic [7:0] exp1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 1'b1, 4'(n), 1'b0, 1'b1);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stats_ready n=%0d got=%0b want=1", n, in_ready); end
            tick();
        end
        exp1 = 8'(300 % 256);
        checks++; if (cnt1 !== exp1) begin failures++; $display("FAIL stats_cnt1 got=%0d want=%0d", cnt1, exp1); end
        checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL stats_cnt0 got=%0d want=0", cnt0); end
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_full();
        test_push_pop();
        test_reset_full();
        test_random();
`ifdef DEMUX1TO2_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
